// File: rtl/fpu_pkg.sv
// Shared floating-point definitions for the FPU datapath blocks.
package fpu_pkg;

    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_MAN_W = 23;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp_t;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_e;

    localparam fp_t QNAN = '{sign: 1'b0, exp: '1, man: {1'b1, {(FP_MAN_W-1){1'b0}}}};

    // Width-independent classification; denormals (exp == 0) count as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_nz);
        fp_class_e c;
        if (exp_zero)
            c = ZERO;
        else if (exp_ones)
            c = man_nz ? NAN : INF;
        else
            c = NORM;
        return c;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input yields W.
module fpu_lzc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]           a_i,
    output logic [$clog2(W+1)-1:0] cnt_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic found;

    // Scan from the MSB, counting zeros until the first set bit.
    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found) begin
                if (a_i[W-1-i])
                    found = 1'b1;
                else
                    cnt_o = cnt_o + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fadd_sub_pipe.sv
// Pipelined IEEE-754 add/subtract with valid/ready handshake, flush-to-zero
// and round-to-nearest-even. One shared enable (adv) moves the whole pipe.
module fadd_sub_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned MAN_W  = FP_MAN_W,
    parameter int unsigned STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op_sub,
    input  logic [EXP_W+MAN_W:0] x1,
    input  logic [EXP_W+MAN_W:0] x2,
    input  logic [3:0]           in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] y,
    output logic                 ovf,
    output logic [3:0]           out_tag
);

    localparam int unsigned FW  = EXP_W + MAN_W + 1;
    // {carry, hidden, mantissa, guard, round, sticky}
    localparam int unsigned W   = MAN_W + 5;
    localparam int unsigned LZW = $clog2(W + 1);
    localparam int unsigned EW  = EXP_W + 2;

    localparam logic [FW-1:0]    QNAN_Y    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [EXP_W-1:0] ALIGN_MAX = EXP_W'(W);
    localparam logic [EW-1:0]    EXP_MAX   = {2'b00, {EXP_W{1'b1}}};

    typedef struct packed {
        logic             vld;
        logic [3:0]       tag;
        logic             spec;
        logic [FW-1:0]    spec_y;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] ea;
        logic [W-1:0]     ma;
        logic [W-1:0]     mb;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic [3:0]       tag;
        logic             spec;
        logic [FW-1:0]    spec_y;
        logic             sign;
        logic [EXP_W-1:0] ea;
        logic [W-1:0]     sum;
        logic [LZW-1:0]   lz;
    } s2_t;

    logic adv;
    logic out_valid_q;
    logic [FW-1:0] y_q;
    logic ovf_q;
    logic [3:0] tag_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign out_tag   = tag_q;

    // ---------------- S1: unpack, special detect, align ----------------
    logic             x2_sign;
    fp_class_e        cls1, cls2;
    logic [EXP_W-1:0] e1, e2, eb, shamt;
    logic [W-1:0]     m1, m2, mb_pre, mb_sh;
    logic             sticky;
    s1_t              s1_d, s1_p;

    assign x2_sign = x2[FW-1] ^ op_sub;
    assign cls1 = fp_classify(x1[FW-2:MAN_W] == '0, x1[FW-2:MAN_W] == '1, x1[MAN_W-1:0] != '0);
    assign cls2 = fp_classify(x2[FW-2:MAN_W] == '0, x2[FW-2:MAN_W] == '1, x2[MAN_W-1:0] != '0);

    // Order operands by magnitude, then shift the smaller right keeping a sticky bit.
    always_comb begin
        s1_d     = '0;
        s1_d.vld = in_valid;
        s1_d.tag = in_tag;
        e1 = (cls1 == ZERO) ? '0 : x1[FW-2:MAN_W];
        e2 = (cls2 == ZERO) ? '0 : x2[FW-2:MAN_W];
        m1 = (cls1 == ZERO) ? '0 : {2'b01, x1[MAN_W-1:0], 3'b000};
        m2 = (cls2 == ZERO) ? '0 : {2'b01, x2[MAN_W-1:0], 3'b000};
        s1_d.eff_sub = x1[FW-1] ^ x2_sign;
        if ({e1, m1} >= {e2, m2}) begin
            s1_d.sign = x1[FW-1];
            s1_d.ea   = e1;
            s1_d.ma   = m1;
            eb        = e2;
            mb_pre    = m2;
        end else begin
            s1_d.sign = x2_sign;
            s1_d.ea   = e2;
            s1_d.ma   = m2;
            eb        = e1;
            mb_pre    = m1;
        end
        shamt = s1_d.ea - eb;
        if (shamt >= ALIGN_MAX) begin
            mb_sh  = '0;
            sticky = |mb_pre;
        end else begin
            mb_sh  = mb_pre >> shamt;
            sticky = |(mb_pre << (ALIGN_MAX - shamt));
        end
        s1_d.mb = {mb_sh[W-1:1], mb_sh[0] | sticky};

        s1_d.spec = 1'b1;
        if (cls1 == NAN || cls2 == NAN)
            s1_d.spec_y = QNAN_Y;
        else if (cls1 == INF && cls2 == INF)
            s1_d.spec_y = (x1[FW-1] == x2_sign) ? {x1[FW-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}} : QNAN_Y;
        else if (cls1 == INF)
            s1_d.spec_y = {x1[FW-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (cls2 == INF)
            s1_d.spec_y = {x2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (cls1 == ZERO && cls2 == ZERO)
            // Only (-0)+(-0) keeps a negative sign; the general path would give +0.
            s1_d.spec_y = {x1[FW-1] & x2_sign, {(FW-1){1'b0}}};
        else begin
            s1_d.spec   = 1'b0;
            s1_d.spec_y = '0;
        end
    end

    // ---------------- S2: add/sub + leading-zero count ----------------
    logic [W-1:0]   sum;
    logic [LZW-1:0] lz;
    s2_t            s2_d, s2_a, s2_p;

    assign sum = s1_p.eff_sub ? (s1_p.ma - s1_p.mb) : (s1_p.ma + s1_p.mb);

    fpu_lzc #(.W(W)) u_lzc (
        .a_i   (sum),
        .cnt_o (lz)
    );

    // Forward S1 context alongside the raw sum and its leading-zero count.
    always_comb begin
        s2_d        = '0;
        s2_d.vld    = s1_p.vld;
        s2_d.tag    = s1_p.tag;
        s2_d.spec   = s1_p.spec;
        s2_d.spec_y = s1_p.spec_y;
        s2_d.sign   = s1_p.sign;
        s2_d.ea     = s1_p.ea;
        s2_d.sum    = sum;
        s2_d.lz     = lz;
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [W-1:0]     shifted;
    logic [EW-1:0]    e_u, e_r;
    logic [MAN_W-1:0] mant;
    logic [MAN_W:0]   mr;
    logic             rnd_up;
    logic [FW-1:0]    y_d;
    logic             ovf_d;

    // Leading one lands at the carry position; exponent is ea + 1 - lz.
    always_comb begin
        shifted = s2_p.sum << s2_p.lz;
        e_u     = EW'(s2_p.ea) + EW'(1) - EW'(s2_p.lz);
        mant    = shifted[W-2:4];
        rnd_up  = shifted[3] & ((|shifted[2:0]) | mant[0]);
        mr      = {1'b0, mant} + (MAN_W+1)'(rnd_up);
        e_r     = e_u + EW'(mr[MAN_W]);
        ovf_d   = 1'b0;
        if (s2_p.spec)
            y_d = s2_p.spec_y;
        else if (!shifted[W-1] || e_u[EW-1] || e_u == '0)
            y_d = '0;
        else if (e_r >= EXP_MAX) begin
            y_d   = {s2_p.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d = 1'b1;
        end else
            y_d = {s2_p.sign, e_r[EXP_W-1:0], mr[MAN_W-1:0]};
    end

    // ---------------- Stage registers (placement depends on STAGES) ----------------
    if (STAGES >= 2) begin : g_s1_reg
        // S1 -> S2 boundary register.
        always_ff @(posedge clk) begin
            if (rst)
                s1_p <= '0;
            else if (adv)
                s1_p <= s1_d;
        end
    end else begin : g_s1_pass
        assign s1_p = s1_d;
    end

    if (STAGES >= 3) begin : g_s2_reg
        // S2 -> S3 boundary register.
        always_ff @(posedge clk) begin
            if (rst)
                s2_a <= '0;
            else if (adv)
                s2_a <= s2_d;
        end
    end else begin : g_s2_pass
        assign s2_a = s2_d;
    end

    if (STAGES >= 4) begin : g_s2x_reg
        // Extra retiming register after S2 for the deepest configuration.
        always_ff @(posedge clk) begin
            if (rst)
                s2_p <= '0;
            else if (adv)
                s2_p <= s2_a;
        end
    end else begin : g_s2x_pass
        assign s2_p = s2_a;
    end

    // Output register: always present, holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            tag_q       <= '0;
        end else if (adv) begin
            out_valid_q <= s2_p.vld;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            tag_q       <= s2_p.tag;
        end
    end

endmodule

// File: tb/tb_fadd_sub_pipe.sv
// Directed bench for fadd_sub_pipe (binary32, 3 stages).
module tb_fadd_sub_pipe;

    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [31:0] x1, x2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;
    logic [3:0]  out_tag;

    fadd_sub_pipe #(
        .EXP_W  (8),
        .MAN_W  (23),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .x1        (x1),
        .x2        (x2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] tag_ctr = 4'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] stream_val(input int i);
        return 32'h3F800000 + i * 32'h00012345;
    endfunction

    task automatic run_one(input string name, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ey, input logic eo);
        int   lat;
        logic got;
        logic [3:0] t;
        t = tag_ctr;
        tag_ctr = tag_ctr + 4'h1;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        op_sub    = op;
        x1        = a;
        x2        = b;
        in_tag    = t;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 20) begin
            @(negedge clk);
            if (out_valid)
                got = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        chk({name, "_lat"}, lat, STAGES);
        chk({name, "_y"}, y, ey);
        chk({name, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
        chk({name, "_tag"}, {28'b0, out_tag}, {28'b0, t});
    endtask

    logic        seen;
    int          prod_i, prod_guard, cons_k, cons_cyc;
    logic        acc, held;
    logic [31:0] hy;
    logic [3:0]  ht;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held for two cycles while offering an operation.
        rst = 1'b1; in_valid = 1'b1; op_sub = 1'b0;
        x1 = 32'h3F800000; x2 = 32'h40000000; in_tag = 4'hA; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_y", y, 32'h0);
        chk("rst_ovf_tag", {27'b0, ovf, out_tag}, 32'd0);
        seen = 1'b0;
        repeat (STAGES + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_ghost", {31'b0, seen}, 32'd0);

        // Directed arithmetic vectors.
        run_one("add_1_2",     1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
        run_one("sub_1_1",     1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0);
        run_one("ovf_max",     1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
        run_one("rne_tie",     1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
        run_one("rne_tie_odd", 1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
        run_one("rne_above",   1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0);
        run_one("rnd_carry",   1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 1'b0);
        run_one("inf_m_inf",   1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0);
        run_one("denorm_add",  1'b0, 32'h00400000, 32'h00000000, 32'h00000000, 1'b0);
        run_one("negz_negz",   1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
        run_one("nan_in",      1'b0, 32'h7FC12345, 32'h3F800000, 32'h7FC00000, 1'b0);
        run_one("inf_p_one",   1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
        run_one("one_m_inf",   1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0);
        run_one("two_m_three", 1'b1, 32'h40000000, 32'h40400000, 32'hBF800000, 1'b0);
        run_one("uflow_flush", 1'b1, 32'h00800000, 32'h00800001, 32'h00000000, 1'b0);
        run_one("min_norm_x2", 1'b0, 32'h00800000, 32'h00800000, 32'h01000000, 1'b0);

        // Reset while two operations are in flight.
        @(posedge clk);
        #1 in_valid = 1'b1; op_sub = 1'b0; x1 = 32'h3F800000; x2 = 32'h3F800000; in_tag = 4'h5;
        @(posedge clk);
        #1 in_tag = 4'h6;
        @(posedge clk);
        #1 rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (STAGES + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_discard", {31'b0, seen}, 32'd0);

        // Back-pressure stream with pseudo-random out_ready.
        fork
            begin
                prod_i = 0;
                prod_guard = 0;
                @(posedge clk);
                #1;
                while (prod_i < 20 && prod_guard < 1000) begin
                    in_valid = 1'b1;
                    op_sub   = 1'b0;
                    x1       = stream_val(prod_i);
                    x2       = stream_val(prod_i);
                    in_tag   = prod_i[3:0];
                    @(negedge clk);
                    acc = in_ready;
                    @(posedge clk);
                    #1;
                    if (acc) prod_i++;
                    prod_guard++;
                end
                in_valid = 1'b0;
            end
            begin
                cons_k = 0;
                cons_cyc = 0;
                held = 1'b0;
                while (cons_k < 20 && cons_cyc < 1000) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cons_cyc++;
                    if (held) begin
                        chk("bp_hold_v", {31'b0, out_valid}, 32'd1);
                        chk("bp_hold_y", y, hy);
                        chk("bp_hold_tag", {28'b0, out_tag}, {28'b0, ht});
                    end
                    held = 1'b0;
                    if (out_valid && out_ready) begin
                        chk("bp_y", y, stream_val(cons_k) + 32'h00800000);
                        chk("bp_tag", {28'b0, out_tag}, {28'b0, cons_k[3:0]});
                        cons_k++;
                    end else if (out_valid) begin
                        held = 1'b1;
                        hy   = y;
                        ht   = out_tag;
                    end
                end
                chk("bp_count", cons_k, 32'd20);
            end
        join

        @(posedge clk);
        #1 out_ready = 1'b1;
        seen = 1'b0;
        repeat (STAGES + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("bp_no_dup", {31'b0, seen}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
